// File: rtl/clk_strobe_gen_if.sv
// Strobe generator interface: speed/pause requests in, timing strobes and the
// effective CPU multiplier out.
interface clk_strobe_gen_if #(
    parameter int MAX_MULT = 2
);
    localparam int MW = (MAX_MULT > 1) ? $clog2(MAX_MULT) : 1;

    logic [MW-1:0] speed;
    logic          pause;
    logic          clk_f1;
    logic          clk_f2;
    logic          clk_periph;
    logic          clk_pix;
    logic          clk_pix2x;
    logic          clk_ps2;
    logic          period_start;
    logic [MW-1:0] mult_o;

    modport master (
        output speed, pause,
        input  clk_f1, clk_f2, clk_periph, clk_pix, clk_pix2x, clk_ps2,
        input  period_start, mult_o
    );

    modport slave (
        input  speed, pause,
        output clk_f1, clk_f2, clk_periph, clk_pix, clk_pix2x, clk_ps2,
        output period_start, mult_o
    );
endinterface

// File: rtl/clk_strobe_gen.sv
// Single-clock strobe generator: CPU f1/f2 pairs at 1..MAX_MULT per period, plus
// peripheral, video and PS/2 strobes. Define STROBE_PS2_EN to build the PS/2 counter.
module clk_strobe_gen #(
    parameter int CPU_DIV       = 28,
    parameter int MAX_MULT      = 2,
    parameter int F2_OFFSET     = 2,
    parameter int PERIPH_OFFSET = 4,
    parameter int PIX_DIV       = 6,
    parameter int PS2_DIV       = 3571
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    clk_strobe_gen_if.slave   bus
);
    localparam int MW  = (MAX_MULT > 1) ? $clog2(MAX_MULT) : 1;
    localparam int PW  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int KW  = $clog2(MAX_MULT + 1);
    localparam int XW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [PW-1:0] phase;
    logic [PW-1:0] slot;
    logic [KW-1:0] k;
    logic [MW-1:0] mult_q;
    logic          armed;
    logic [XW-1:0] pix_cnt;

    logic [PW-1:0] slot_last_tab [MAX_MULT];
    logic [PW-1:0] slot_last;
    logic [MW-1:0] speed_clamped;
    logic          k_active;

    // Last slot index for each multiplier, fixed at elaboration.
    for (genvar m = 0; m < MAX_MULT; m++) begin : g_slot_tab
        assign slot_last_tab[m] = PW'(CPU_DIV / (m + 1) - 1);
    end

    assign slot_last     = slot_last_tab[mult_q];
    assign speed_clamped = (int'(bus.speed) >= MAX_MULT) ? MW'(MAX_MULT - 1) : bus.speed;
    assign k_active      = (int'(k) <= int'(mult_q));

    // NOTE: every register below uses <= so all strobes decode the same
    // pre-edge counter values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= '0;
            slot   <= '0;
            k      <= '0;
            mult_q <= '0;
        end else if (phase == PW'(CPU_DIV - 1)) begin
            phase  <= '0;
            slot   <= '0;
            k      <= '0;
            mult_q <= speed_clamped;
        end else begin
            phase <= phase + 1'b1;
            if (slot != slot_last) begin
                slot <= slot + 1'b1;
            end else if (k_active) begin
                // The last slot of the period parks at slot_last until the wrap.
                k <= k + 1'b1;
                if (int'(k) < int'(mult_q)) slot <= '0;
            end
        end
    end

    // armed stays set only while pause has been low since this slot's f1 edge,
    // so an f2 can never appear without its matching f1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (slot == '0) begin
            armed <= !bus.pause;
        end else begin
            armed <= armed && !bus.pause;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bus.clk_f1       <= 1'b0;
            bus.clk_f2       <= 1'b0;
            bus.clk_periph   <= 1'b0;
            bus.period_start <= 1'b0;
        end else begin
            bus.clk_f1       <= (slot == '0) && k_active && !bus.pause;
            bus.clk_f2       <= (slot == PW'(F2_OFFSET)) && k_active && !bus.pause &&
                                (armed || (F2_OFFSET == 0));
            bus.clk_periph   <= (phase == PW'(PERIPH_OFFSET));
            bus.period_start <= (phase == '0);
        end
    end

    assign bus.mult_o = mult_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt       <= '0;
            bus.clk_pix   <= 1'b0;
            bus.clk_pix2x <= 1'b0;
        end else begin
            pix_cnt       <= (pix_cnt == XW'(PIX_DIV - 1)) ? '0 : pix_cnt + 1'b1;
            bus.clk_pix   <= (pix_cnt == '0);
            bus.clk_pix2x <= (pix_cnt == '0) || (pix_cnt == XW'(PIX_DIV / 2));
        end
    end

`ifdef STROBE_PS2_EN
    localparam int SW = (PS2_DIV > 1) ? $clog2(PS2_DIV) : 1;
    logic [SW-1:0] ps2_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_cnt     <= '0;
            bus.clk_ps2 <= 1'b0;
        end else begin
            ps2_cnt     <= (ps2_cnt == SW'(PS2_DIV - 1)) ? '0 : ps2_cnt + 1'b1;
            bus.clk_ps2 <= (ps2_cnt == '0);
        end
    end
`else
    assign bus.clk_ps2 = 1'b0 && (PS2_DIV > 0);
`endif
endmodule
